// File: rtl/pipe_pkg.sv
// Shared definitions for the ID->EX pipeline stage.
// Default widths, NOP encodings and the packed decode payload.
package pipe_pkg;

  localparam int DATA_W_DEF      = 32;
  localparam int ADDR_W_DEF      = 5;
  localparam int OP_W_DEF        = 8;
  localparam int SEL_W_DEF       = 3;
  localparam int STALL_CNT_W_DEF = 16;

  localparam int ALU_SEL_NOP = 0;
  localparam int ALU_OP_NOP  = 0;

  typedef struct packed {
    logic [SEL_W_DEF-1:0]  sel;
    logic [OP_W_DEF-1:0]   op;
    logic [DATA_W_DEF-1:0] src1;
    logic [DATA_W_DEF-1:0] src2;
    logic [ADDR_W_DEF-1:0] waddr;
    logic                  wen;
  } pipe_payload_t;

endpackage

// File: rtl/pipe_skid_buf.sv
// Two-entry valid/ready buffer: main entry drives the output,
// skid entry absorbs one beat so in_ready never depends on out_ready.
import pipe_pkg::*;

module pipe_skid_buf #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         r_main_valid;
  logic         r_skid_valid;
  logic [W-1:0] r_main_data;
  logic [W-1:0] r_skid_data;
  logic         w_accept;
  logic         w_deliver;

  // Only state and reset feed in_ready; out_ready never does.
  assign in_ready  = ~r_skid_valid & ~reset;
  assign w_accept  = in_valid & in_ready;
  assign w_deliver = r_main_valid & out_ready;
  assign out_valid = r_main_valid;
  assign out_data  = r_main_data;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
      r_main_data  <= '0;
      r_skid_data  <= '0;
    end else if (!r_main_valid) begin
      if (w_accept) begin
        r_main_valid <= 1'b1;
        r_main_data  <= in_data;
      end
    end else if (w_deliver) begin
      if (r_skid_valid) begin
        r_main_data  <= r_skid_data;
        r_skid_valid <= 1'b0;
        r_skid_data  <= '0;
      end else if (w_accept) begin
        r_main_data  <= in_data;
      end else begin
        r_main_valid <= 1'b0;
        r_main_data  <= '0;
      end
    end else if (w_accept) begin
      r_skid_valid <= 1'b1;
      r_skid_data  <= in_data;
    end
  end

endmodule

// File: rtl/pipe_decode_stage.sv
// ID->EX pipeline register with handshake, flush-to-bubble
// and a saturating stall counter.
import pipe_pkg::*;

module pipe_decode_stage #(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int OP_W        = OP_W_DEF,
  parameter int SEL_W       = SEL_W_DEF,
  parameter int STALL_CNT_W = STALL_CNT_W_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [SEL_W-1:0]       alu_sel,
  input  logic [OP_W-1:0]        alu_op,
  input  logic [DATA_W-1:0]      src_data1,
  input  logic [DATA_W-1:0]      src_data2,
  input  logic [ADDR_W-1:0]      wr_addr,
  input  logic                   wr_en,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [SEL_W-1:0]       pipe_alu_sel,
  output logic [OP_W-1:0]        pipe_alu_op,
  output logic [DATA_W-1:0]      pipe_src_data1,
  output logic [DATA_W-1:0]      pipe_src_data2,
  output logic [ADDR_W-1:0]      pipe_wr_addr,
  output logic                   pipe_wr_en,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  typedef struct packed {
    logic [SEL_W-1:0]  sel;
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] src1;
    logic [DATA_W-1:0] src2;
    logic [ADDR_W-1:0] waddr;
    logic              wen;
  } pay_t;

  localparam int PW = $bits(pay_t);

  pay_t                   w_in;
  pay_t                   w_out;
  logic [PW-1:0]          w_out_bits;
  logic [STALL_CNT_W-1:0] r_stall_cnt;

  assign w_in  = '{sel: alu_sel, op: alu_op, src1: src_data1,
                   src2: src_data2, waddr: wr_addr, wen: wr_en};
  assign w_out = pay_t'(w_out_bits);

  pipe_skid_buf #(.W(PW)) u_buf (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (w_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (w_out_bits)
  );

  // A bubble must never look like a live ALU op or a register write.
  assign pipe_alu_sel   = out_valid ? w_out.sel : SEL_W'(ALU_SEL_NOP);
  assign pipe_alu_op    = out_valid ? w_out.op : OP_W'(ALU_OP_NOP);
  assign pipe_src_data1 = w_out.src1;
  assign pipe_src_data2 = w_out.src2;
  assign pipe_wr_addr   = w_out.waddr;
  assign pipe_wr_en     = w_out.wen & out_valid;
  assign stall_cnt      = r_stall_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cnt <= '0;
    end else if (out_valid && !out_ready && !(&r_stall_cnt)) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

endmodule
